uart_rx_lite: RTL
=================

Name: uart_rx_lite

Overview:
- Serial receiver for one TinyTapeout input pin.
- Accepts 8N1 asynchronous frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed clock/bit ratio and presents each byte as a parallel word with a one-cycle valid strobe.
- Optional line inversion supports inverted-polarity links, such as a level shifter or inverter stage in front of the pin.
- Sits between a top-level `ui_in` bit and downstream byte logic driving `uo_out`.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be even and >= 4.
- INVERT, 0, 1 = the line is inverted before decoding (idle low, start bit high).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_in  input  1  raw serial line from the pin; asynchronous to clk
- data_out  output  8  last correctly received byte
- valid  output  1  one-cycle pulse; data_out is new this cycle
- frame_err  output  1  sticky flag: last frame had stop bit = 0
- busy  output  1  high while a frame is being received (any state other than IDLE)

Behaviour:
- Reset, sampled on the rising clk edge while rst = 1:
  - data_out = 0x00, valid = 0, frame_err = 0, busy = 0.
  - State = IDLE, bit counter = 0, cycle counter = 0.
  - Both synchronizer flops preset to the idle level, 1 ^ INVERT.
  - Reset asserted mid-frame aborts the frame immediately: no valid, frame_err cleared.
- Input path:
  - 2-flop synchronizer on rx_in.
  - line = sync_q ^ INVERT.
  - Pin-to-line latency is 2 cycles. All decoding uses `line` only.
- Timing notation: N = CLKS_PER_BIT, H = N/2. Cycle counter width is clog2(N).
- State machine:
  - IDLE: busy = 0. When line = 0, go to START, cycle counter = 0. Call this cycle t0.
  - START: count to H-1, then sample line (cycle t0+H).
    - line = 0: go to DATA, cycle counter = 0, bit counter = 0.
    - line = 1: glitch; return to IDLE with no outputs changed.
  - DATA: every N cycles, sample line into shift[bit], LSB first.
    - Bit i is sampled at t0+H+(i+1)*N.
    - After bit 7 go to STOP.
  - STOP: sample line at t0+H+9N.
    - line = 1: data_out <= shift, valid = 1 for exactly the next cycle, frame_err <= 0; go to IDLE.
    - line = 0: frame_err <= 1, no valid, data_out unchanged; go to BREAK.
  - BREAK: busy = 1. Wait until line = 1, then go to IDLE. A held-low line (break condition) never produces a frame.
- Latency: valid rises at cycle t0+H+9N+1, i.e. 2 + H + 9N + 1 cycles after the falling edge at the pin.
- Back-to-back frames:
  - IDLE is re-entered in the same cycle valid rises.
  - A start bit that begins immediately after the stop sample is detected with no lost cycles.
  - No minimum gap beyond H cycles of stop bit is required.
- data_out holds its value until the next good frame.
- frame_err stays set until the next good frame or reset.
- valid is never high for two consecutive cycles.

Test Plan:
- CLKS_PER_BIT=16, INVERT=0, send 0xA5 -> one valid pulse, data_out=0xA5, frame_err=0, valid at 2+8+144+1=155 cycles after the start edge at the pin.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles apart, data_out 0x00 then 0xFF, busy low for 1 cycle between frames at most.
- Low glitch of 4 cycles on an idle line -> no valid, busy high for about 8 cycles then 0, data_out unchanged.
- Frame 0x3C with stop bit forced 0, then line held low for 50 cycles, then 0x11 sent normally:
  - First frame -> frame_err=1, no valid, busy stays high during the low hold.
  - Then 0x11 -> valid, data_out=0x11, frame_err=0.
- INVERT=1 with a fully inverted waveform of 0x3C -> data_out=0x3C, valid pulse, frame_err=0.
- rst pulsed high during data bit 4 of 0x5A, then 0x81 sent -> no output for 0x5A, all outputs 0 after reset, then data_out=0x81 with one valid pulse.

Source files
------------

// File: rtl/uart_rx_lite.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle valid
// strobe, sticky stop-bit error flag and optional line inversion.
module uart_rx_lite #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit INVERT       = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          IDLE_LVL  = 1'b1 ^ INVERT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          valid_n, err_n;
  logic          sync1, sync2, line;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LVL;
      sync2 <= IDLE_LVL;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

  assign line = sync2 ^ INVERT;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = data_out;
    valid_n = 1'b0;
    err_n   = frame_err;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!line) state_n = S_START;
      end
      S_START: begin
        // Half a bit in: a start bit that has gone high again was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (!line) begin
            state_n = S_DATA;
            bit_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shift_n[bit_cnt] = line;
          bit_n            = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (line) begin
            data_n  = shift;
            valid_n = 1'b1;
            err_n   = 1'b0;
            state_n = S_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (line) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
